// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types for the UART receive path. Holds the receiver
//                state encoding used by uart_rx_axis.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Receiver frame-tracking states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,   // line idle, waiting for a falling edge
        START = 3'd1,   // validating the start bit at its midpoint
        DATA  = 3'd2,   // sampling data bits, LSB first
        STOP  = 3'd3,   // sampling the stop bit
        BREAK = 3'd4    // stop bit was low; wait for the line to go idle
    } uart_rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sync2.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync2
//  Description : Two-flop synchroniser for a single asynchronous input.
//                The reset value is a parameter so the block can sit on
//                pins that idle either high or low.
//  Ports       : clk      - destination clock
//                rstn     - asynchronous active-low reset
//                i_async  - asynchronous input
//                o_sync   - input synchronised to clk (2-cycle latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_sync2 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_async,
    output logic o_sync
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= i_async;
            sync_q <= meta_q;
        end
    end

    assign o_sync = sync_q;

endmodule
`default_nettype wire

// File: rtl/uart_rx_axis.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_axis
//  Description : 8N1-style UART receiver with a one-entry registered
//                AXI-Stream master output. Bits are sampled at mid-period
//                after a validated start bit. A good stop bit delivers the
//                word, a low stop bit pulses frame_err, and a word arriving
//                while the output is still full is dropped with an overrun
//                pulse.
//  Ports       : clk, rstn        - clock, asynchronous active-low reset
//                UART_RX          - serial input, asynchronous, idle high
//                m_axis_data      - received word (LSB = first bit on line)
//                m_axis_valid     - word available
//                m_axis_ready     - downstream accepts
//                overrun          - 1-cycle pulse, word lost to a full output
//                frame_err        - 1-cycle pulse, stop bit sampled low
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_axis
    import uart_pkg::*;
#(
    parameter int CLKRATE     = 50000000,
    parameter int BAUD        = 115200,
    parameter int WORD_LENGTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   UART_RX,
    output logic [WORD_LENGTH-1:0] m_axis_data,
    output logic                   m_axis_valid,
    input  logic                   m_axis_ready,
    output logic                   overrun,
    output logic                   frame_err
);

    localparam int CLKS_PER_BIT = CLKRATE / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W        = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;

    localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [IDX_W-1:0] C_IDX_LAST  = IDX_W'(WORD_LENGTH - 1);

    logic                   w_rx_s;

    uart_rx_state_t         state_q,   state_d;
    logic [CNT_W-1:0]       cnt_q,     cnt_d;
    logic [IDX_W-1:0]       idx_q,     idx_d;
    logic [WORD_LENGTH-1:0] shift_q,   shift_d;
    logic [WORD_LENGTH-1:0] data_q,    data_d;
    logic                   valid_q,   valid_d;
    logic                   overrun_q, overrun_d;
    logic                   ferr_q,    ferr_d;

    uart_sync2 #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk     (clk),
        .rstn    (rstn),
        .i_async (UART_RX),
        .o_sync  (w_rx_s)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            ferr_q    <= ferr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        ferr_d    = 1'b0;

        // Handshake first; a delivery in the same cycle overrides it below,
        // so valid stays high with the new word.
        if (valid_q && m_axis_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!w_rx_s) begin
                    state_d = START;
                end
            end

            START: begin
                if (cnt_q == C_HALF_LAST) begin
                    cnt_d   = '0;
                    // Line back high at mid start bit: treat as a glitch.
                    state_d = w_rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            DATA: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = w_rx_s;
                    if (idx_q == C_IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            STOP: begin
                if (cnt_q == C_BIT_LAST) begin
                    cnt_d = '0;
                    if (w_rx_s) begin
                        // Return to IDLE at mid stop bit so a start bit that
                        // follows immediately is still caught.
                        state_d = IDLE;
                        if (!valid_q || m_axis_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            BREAK: begin
                cnt_d = '0;
                if (w_rx_s) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign m_axis_data  = data_q;
    assign m_axis_valid = valid_q;
    assign overrun      = overrun_q;
    assign frame_err    = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_axis.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_axis
//  Description : Self-checking bench for uart_rx_axis at 1 MHz / 100 kbaud
//                (10 clocks per bit). A vector table of single frames,
//                hand-written multi-frame sequences and a randomised run
//                against a queue-based model of the expected words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_axis;
    import uart_pkg::*;

    localparam int CPB = 10;
    localparam int LAT = 98;

    logic       clk          = 1'b0;
    logic       rstn         = 1'b0;
    logic       UART_RX      = 1'b1;
    logic       m_axis_ready = 1'b0;
    logic [7:0] m_axis_data;
    logic       m_axis_valid;
    logic       overrun;
    logic       frame_err;

    uart_rx_axis #(
        .CLKRATE     (1000000),
        .BAUD        (100000),
        .WORD_LENGTH (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .UART_RX      (UART_RX),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .overrun      (overrun),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    // Ready driver: fixed level or random, applied 2 time units after the edge.
    bit rand_ready  = 1'b0;
    bit ready_fixed = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #2;
            m_axis_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_fixed;
        end
    end

    // Output monitor: collects accepted words, pulse counts and AXIS rules.
    logic [7:0] got_q[$];
    int         ferr_cnt   = 0;
    int         ovr_cnt    = 0;
    int         vhigh_cnt  = 0;
    int         rise_cyc   = -1;
    int         ovr_cyc    = -1;
    int         fall_cyc   = 0;
    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_ferr  = 1'b0;
    logic       prev_ovr   = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    always @(negedge clk) begin
        if (rstn) begin
            if (m_axis_valid && m_axis_ready) got_q.push_back(m_axis_data);
            if (m_axis_valid) vhigh_cnt++;
            if (m_axis_valid && !prev_valid) rise_cyc = cyc;
            if (prev_valid && !prev_ready) begin
                check("hold_valid", int'(m_axis_valid), 1);
                check("hold_data", int'(m_axis_data), int'(prev_data));
            end
            if (frame_err) begin
                ferr_cnt++;
                check("ferr_width", int'(prev_ferr), 0);
                check("ferr_ovr_excl", int'(overrun), 0);
            end
            if (overrun) begin
                ovr_cnt++;
                ovr_cyc = cyc;
                check("ovr_width", int'(prev_ovr), 0);
            end
            prev_valid = m_axis_valid;
            prev_ready = m_axis_ready;
            prev_ferr  = frame_err;
            prev_ovr   = overrun;
            prev_data  = m_axis_data;
        end else begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_ferr  = 1'b0;
            prev_ovr   = 1'b0;
            prev_data  = 8'h00;
        end
    end

    // Line drivers. All tasks start and end 1 time unit after a rising edge.
    task automatic hold_bit(input logic v);
        UART_RX = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        UART_RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold_low(input int n);
        UART_RX = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_val);
        logic [7:0] b;
        b        = d;
        fall_cyc = cyc;
        hold_bit(1'b0);
        for (int i = 0; i < 8; i++) hold_bit(b[i]);
        hold_bit(stop_val);
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop_ok;
        logic       ready;
        int         exp_words;
        int         exp_ferr;
        logic       exp_held;
        int         exp_vhigh;   // -1: not checked
        logic [7:0] exp_data;
    } vec_t;

    localparam int NV = 7;
    vec_t vec[NV];

    int         base_got, base_ferr, base_ovr, base_vh, nbad;
    logic [7:0] exp_q[$];
    logic [7:0] rd;
    logic       rok;

    initial begin
        vec[0] = '{8'hA5, 1'b1, 1'b1, 1, 0, 1'b0,  1, 8'hA5};
        vec[1] = '{8'h00, 1'b1, 1'b1, 1, 0, 1'b0,  1, 8'h00};
        vec[2] = '{8'hFF, 1'b1, 1'b1, 1, 0, 1'b0,  1, 8'hFF};
        vec[3] = '{8'h55, 1'b0, 1'b1, 0, 1, 1'b0,  0, 8'h00};
        vec[4] = '{8'h12, 1'b1, 1'b1, 1, 0, 1'b0,  1, 8'h12};
        vec[5] = '{8'h3C, 1'b1, 1'b0, 0, 0, 1'b1, -1, 8'h3C};
        vec[6] = '{8'h81, 1'b1, 1'b1, 1, 0, 1'b0,  1, 8'h81};

        // Reset state
        rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", int'(m_axis_valid), 0);
        check("rst_data", int'(m_axis_data), 0);
        check("rst_overrun", int'(overrun), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_state", int'(dut.state_q), int'(IDLE));
        rstn = 1'b1;
        idle(5);

        // Table of single frames
        for (int i = 0; i < NV; i++) begin
            ready_fixed = vec[i].ready;
            idle(1);
            base_got  = got_q.size();
            base_ferr = ferr_cnt;
            base_vh   = vhigh_cnt;
            rise_cyc  = -1;
            send_frame(vec[i].data, vec[i].stop_ok);
            if (!vec[i].stop_ok) hold_low(30);
            idle(20);
            check($sformatf("v%0d_words", i), got_q.size() - base_got, vec[i].exp_words);
            if (vec[i].exp_words > 0 && got_q.size() > 0)
                check($sformatf("v%0d_data", i), int'(got_q[got_q.size()-1]), int'(vec[i].exp_data));
            check($sformatf("v%0d_ferr", i), ferr_cnt - base_ferr, vec[i].exp_ferr);
            if (vec[i].stop_ok)
                check($sformatf("v%0d_latency", i), rise_cyc - fall_cyc, LAT);
            if (vec[i].exp_vhigh >= 0)
                check($sformatf("v%0d_valid_cycles", i), vhigh_cnt - base_vh, vec[i].exp_vhigh);
            if (vec[i].exp_held) begin
                check($sformatf("v%0d_held_valid", i), int'(m_axis_valid), 1);
                check($sformatf("v%0d_held_data", i), int'(m_axis_data), int'(vec[i].exp_data));
                ready_fixed = 1'b1;
                idle(4);
                check($sformatf("v%0d_drain_words", i), got_q.size() - base_got, 1);
                if (got_q.size() > 0)
                    check($sformatf("v%0d_drain_data", i), int'(got_q[got_q.size()-1]), int'(vec[i].exp_data));
                check($sformatf("v%0d_drain_valid", i), int'(m_axis_valid), 0);
            end
        end

        // Back-to-back frames, ready high
        ready_fixed = 1'b1;
        idle(3);
        got_q.delete();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        idle(20);
        check("b2b_count", got_q.size(), 3);
        if (got_q.size() == 3) begin
            check("b2b_w0", int'(got_q[0]), 8'h00);
            check("b2b_w1", int'(got_q[1]), 8'hFF);
            check("b2b_w2", int'(got_q[2]), 8'h3C);
        end

        // Two-cycle glitch on the idle line
        base_got  = got_q.size();
        base_ferr = ferr_cnt;
        base_ovr  = ovr_cnt;
        base_vh   = vhigh_cnt;
        hold_low(2);
        idle(20);
        check("glitch_words", got_q.size() - base_got, 0);
        check("glitch_valid", vhigh_cnt - base_vh, 0);
        check("glitch_ferr", ferr_cnt - base_ferr, 0);
        check("glitch_ovr", ovr_cnt - base_ovr, 0);
        check("glitch_state", int'(dut.state_q), int'(IDLE));

        // Overrun: two frames with ready low
        ready_fixed = 1'b0;
        idle(3);
        base_got = got_q.size();
        base_ovr = ovr_cnt;
        ovr_cyc  = -1;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(20);
        check("ovr_count", ovr_cnt - base_ovr, 1);
        check("ovr_timing", ovr_cyc - fall_cyc, LAT);
        check("ovr_valid", int'(m_axis_valid), 1);
        check("ovr_data", int'(m_axis_data), 8'h11);
        ready_fixed = 1'b1;
        idle(4);
        check("ovr_drain_words", got_q.size() - base_got, 1);
        if (got_q.size() > base_got)
            check("ovr_drain_data", int'(got_q[got_q.size()-1]), 8'h11);
        check("ovr_drain_valid", int'(m_axis_valid), 0);

        // Reset mid-DATA with a word held on the output
        ready_fixed = 1'b0;
        idle(3);
        send_frame(8'h99, 1'b1);
        idle(5);
        check("pre_rst_valid", int'(m_axis_valid), 1);
        hold_bit(1'b0);              // start bit of 0x77
        hold_bit(1'b1);
        hold_bit(1'b1);
        hold_bit(1'b1);
        hold_low(5);                 // middle of data bit 3
        check("pre_rst_state", int'(dut.state_q), int'(DATA));
        rstn = 1'b0;
        #1;
        check("mid_rst_valid", int'(m_axis_valid), 0);
        check("mid_rst_data", int'(m_axis_data), 0);
        check("mid_rst_overrun", int'(overrun), 0);
        check("mid_rst_ferr", int'(frame_err), 0);
        check("mid_rst_state", int'(dut.state_q), int'(IDLE));
        UART_RX = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rstn        = 1'b1;
        ready_fixed = 1'b1;
        base_got    = got_q.size();
        base_ferr   = ferr_cnt;
        idle(20);
        check("post_rst_words", got_q.size() - base_got, 0);
        check("post_rst_ferr", ferr_cnt - base_ferr, 0);
        send_frame(8'h88, 1'b1);
        idle(15);
        check("post_rst_rx_words", got_q.size() - base_got, 1);
        if (got_q.size() > base_got)
            check("post_rst_rx_data", int'(got_q[got_q.size()-1]), 8'h88);

        // Randomised frames, random ready, checked against an ordered model
        got_q.delete();
        exp_q.delete();
        base_ferr  = ferr_cnt;
        base_ovr   = ovr_cnt;
        nbad       = 0;
        rand_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            rd  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 3) != 0);
            send_frame(rd, rok);
            if (rok) begin
                exp_q.push_back(rd);
                idle($urandom_range(0, 8));
            end else begin
                nbad++;
                hold_low($urandom_range(0, 20));
                idle($urandom_range(2, 8));
            end
        end
        idle(40);
        rand_ready  = 1'b0;
        ready_fixed = 1'b1;
        idle(5);
        check("rand_count", got_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k < got_q.size())
                check($sformatf("rand_w%0d", k), int'(got_q[k]), int'(exp_q[k]));
        end
        check("rand_ferr", ferr_cnt - base_ferr, nbad);
        check("rand_ovr", ovr_cnt - base_ovr, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
